spi_slave: RTL and testbench

- SPI slave front end; sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit command/data words, presented on rx_data with a one-cycle rx_valid strobe.
- On read-data frames, waits for the RAM's tx_valid/tx_data. It then serialises the returned byte MSB-first on MISO.
- The clk port is the SPI serial clock (mode 0). All sampling and driving happens on its rising edge.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_tx_serializer.sv | 84 ++++++++
 rtl/spi_slave.sv | 109 ++++++++++
 tb/tb_spi_slave.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : shared states, command encodings and width defaults for spi_slave.
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam int DEF_WORD_W = 10;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_tx_serializer : loads a byte, shifts it MSB-first onto MISO, flags done.
// Optional odd-parity trailer bit: SPI_SLAVE_MISO_PARITY_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-2:0] shift_q;
  logic [CNT_W-1:0]  remain;
  logic              busy;
  logic              last;

`ifdef SPI_SLAVE_MISO_PARITY_EN
  logic parity_q;
  logic parity_phase;
  assign last = busy && (remain == '0) && parity_phase;
`else
  assign last = busy && (remain == '0);
`endif

  // An abort on the same edge as the final bit counts as an abort, not completion.
  assign done = last && enable && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      remain  <= '0;
      busy    <= 1'b0;
      miso    <= 1'b0;
`ifdef SPI_SLAVE_MISO_PARITY_EN
      parity_q     <= 1'b0;
      parity_phase <= 1'b0;
`endif
    end else if (clear) begin
      busy <= 1'b0;
      miso <= 1'b0;
`ifdef SPI_SLAVE_MISO_PARITY_EN
      parity_phase <= 1'b0;
`endif
    end else if (load) begin
      miso    <= data[DATA_W-1];
      shift_q <= data[DATA_W-2:0];
      remain  <= CNT_W'(DATA_W - 1);
      busy    <= 1'b1;
`ifdef SPI_SLAVE_MISO_PARITY_EN
      parity_q     <= ~^data;
      parity_phase <= 1'b0;
`endif
    end else if (busy && enable) begin
      if (remain != '0) begin
        miso    <= shift_q[DATA_W-2];
        shift_q <= {shift_q[DATA_W-3:0], 1'b0};
        remain  <= remain - CNT_W'(1);
      end
`ifdef SPI_SLAVE_MISO_PARITY_EN
      else if (!parity_phase) begin
        miso         <= parity_q;
        parity_phase <= 1'b1;
      end
`endif
      else begin
        miso <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave : SPI mode-0 slave, 10-bit word deserialiser with RAM read-back.
// Optional MISO parity trailer: SPI_SLAVE_MISO_PARITY_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
  localparam logic [3:0] WAIT_TX  = 4'(WORD_W);

  state_t            state;
  state_t            next_state;
  logic [3:0]        bit_cnt;
  logic [WORD_W-2:0] shift_q;
  logic              rd_addr_done;

  logic shift_en;
  logic rx_fire;
  logic tx_load;
  logic tx_abort;
  logic tx_en;
  logic tx_done;

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    rx_fire    = 1'b0;
    tx_load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!SS_n) next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_done) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          next_state = IDLE;
        end else if (bit_cnt <= LAST_BIT) begin
          shift_en = 1'b1;
          rx_fire  = (bit_cnt == LAST_BIT);
        end else if ((state == READ_DATA) && (bit_cnt == WAIT_TX) && tx_valid) begin
          // Counter moves past WAIT_TX so a late tx_valid is ignored.
          tx_load = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign tx_abort = (state != IDLE) && (next_state == IDLE);
  assign tx_en    = (state == READ_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_valid <= rx_fire;
      if (next_state != state)      bit_cnt <= '0;
      else if (shift_en || tx_load) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) shift_q <= {shift_q[WORD_W-3:0], MOSI};
      if (rx_fire)  rx_data <= {shift_q, MOSI};
      if (rx_fire && (state == READ_ADD)) rd_addr_done <= 1'b1;
      else if (tx_done)                   rd_addr_done <= 1'b0;
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_serializer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tx_abort),
    .load   (tx_load),
    .enable (tx_en),
    .data   (tx_data),
    .miso   (MISO),
    .done   (tx_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_slave : randomized bench for spi_slave against a frame-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_slave;
  import spi_pkg::*;

`ifdef SPI_SLAVE_MISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ss_n     = 1'b1;
  logic       mosi     = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso;
  logic       rx_valid;
  logic [9:0] rx_data;

  int n_cmp  = 0;
  int n_fail = 0;

  int         o_strobes, o_edge, o_stray;
  logic [9:0] o_data, o_mbits, o_rst_data;
  logic       o_rst_miso, o_rst_valid;

  bit         m_rd_done;
  int         x_strobes;
  logic [9:0] x_mbits;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // Frame-level model: one strobe per complete frame; a read-data frame returns
  // the byte (plus optional odd parity) and clears the address-done flag.
  task automatic model_frame(input bit cmdb, input bit complete, input logic [7:0] txb,
                             input int miso_cut, input bit cut_rst);
    x_strobes = complete ? 1 : 0;
    x_mbits   = '0;
    if (complete && cmdb) begin
      if (!m_rd_done) begin
        m_rd_done = 1'b1;
      end else begin
        x_mbits = {txb, (PAR_EN ? ~^txb : 1'b0), 1'b0};
        for (int j = miso_cut; j < 10; j++) x_mbits[9-j] = 1'b0;
        if (miso_cut >= 10) m_rd_done = 1'b0;
      end
    end
    if (cut_rst) m_rd_done = 1'b0;
  endtask

  task automatic sample(input int e, input bit chk_miso);
    if (rx_valid === 1'b1) begin
      o_strobes++;
      o_edge = e;
      o_data = rx_data;
    end
    if (chk_miso && (miso !== 1'b0)) o_stray++;
  endtask

  task automatic run_frame(input bit cmdb, input logic [9:0] word, input int nbits, input bit abort,
                           input logic [7:0] txb, input int miso_cut, input bit cut_rst);
    int e;
    o_strobes = 0; o_edge = -1; o_stray = 0; o_data = '0; o_mbits = '0;
    ss_n = 1'b0;
    mosi = 1'($urandom);
    @(posedge clk); e = 1;
    @(negedge clk); sample(e, 1'b1); mosi = cmdb;
    @(posedge clk); e = 2;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); sample(e, 1'b1);
      mosi = word[9-i];
      if (abort && (i == nbits - 1)) ss_n = 1'b1;
      @(posedge clk); e++;
    end
    if (!abort) begin
      for (int k = 0; (k < 4) && (o_strobes == 0); k++) begin
        @(negedge clk); sample(e, 1'b1);
        mosi = 1'($urandom);
        if (o_strobes == 0) begin @(posedge clk); e++; end
      end
      if (o_strobes != 0) begin
        tx_valid = 1'b1;
        tx_data  = txb;
        @(posedge clk); e++;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          if (j == 0) begin tx_valid = 1'b0; tx_data = 8'($urandom); end
          if (j == miso_cut) begin
            if (cut_rst) begin
              #2 rst_n = 1'b0;
              #1;
              o_rst_miso  = miso;
              o_rst_valid = rx_valid;
              o_rst_data  = rx_data;
            end
            ss_n = 1'b1;
            break;
          end
          sample(e, 1'b0);
          o_mbits[9-j] = miso;
          @(posedge clk); e++;
        end
      end
    end
    @(negedge clk); sample(e, 1'b1);
    ss_n  = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); e++;
      @(negedge clk); sample(e, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; m_rd_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({miso, rx_valid} !== 2'b00) begin n_fail++; $display("FAIL idle_outputs: got %b want 00", {miso, rx_valid}); end
  endtask

  task automatic test_write_addr();
    logic [7:0] t;
    t = 8'($urandom);
    model_frame(1'b0, 1'b1, t, 10, 1'b0);
    run_frame(1'b0, 10'h0A5, 10, 1'b0, t, 10, 1'b0);
    n_cmp++; if (o_strobes !== 1) begin n_fail++; $display("FAIL wa_strobes: got %0d want 1", o_strobes); end
    n_cmp++; if (o_edge !== 12) begin n_fail++; $display("FAIL wa_edge: got %0d want 12", o_edge); end
    n_cmp++; if (o_data !== 10'h0A5) begin n_fail++; $display("FAIL wa_data: got %h want 0a5", o_data); end
    n_cmp++; if ((o_mbits !== 10'h000) || (o_stray !== 0)) begin
      n_fail++; $display("FAIL wa_miso: got bits %b stray %0d want all 0", o_mbits, o_stray);
    end
  endtask

  task automatic test_write_data();
    logic [7:0] t;
    t = 8'($urandom);
    model_frame(1'b0, 1'b1, t, 10, 1'b0);
    run_frame(1'b0, 10'h13C, 10, 1'b0, t, 10, 1'b0);
    n_cmp++; if (o_strobes !== x_strobes) begin n_fail++; $display("FAIL wd_strobes: got %0d want %0d", o_strobes, x_strobes); end
    n_cmp++; if (o_data !== 10'h13C) begin n_fail++; $display("FAIL wd_data: got %h want 13c", o_data); end
    n_cmp++; if (rx_data !== 10'h13C) begin n_fail++; $display("FAIL wd_hold: got %h want 13c", rx_data); end
    n_cmp++; if (o_mbits !== x_mbits) begin n_fail++; $display("FAIL wd_miso: got %b want %b", o_mbits, x_mbits); end
  endtask

  task automatic test_read_seq();
    logic [9:0] w;
    model_frame(1'b1, 1'b1, 8'h00, 10, 1'b0);
    run_frame(1'b1, 10'h207, 10, 1'b0, 8'h00, 10, 1'b0);
    n_cmp++; if (o_data !== 10'h207) begin n_fail++; $display("FAIL ra_data: got %h want 207", o_data); end
    n_cmp++; if (o_mbits !== x_mbits) begin n_fail++; $display("FAIL ra_miso: got %b want %b", o_mbits, x_mbits); end
    w = {CMD_RD_DATA, 8'($urandom)};
    model_frame(1'b1, 1'b1, 8'hC3, 10, 1'b0);
    run_frame(1'b1, w, 10, 1'b0, 8'hC3, 10, 1'b0);
    n_cmp++; if (o_data[9:8] !== CMD_RD_DATA) begin n_fail++; $display("FAIL rd_cmd: got %b want 11", o_data[9:8]); end
    n_cmp++; if (o_edge !== 12) begin n_fail++; $display("FAIL rd_edge: got %0d want 12", o_edge); end
    n_cmp++; if (o_mbits[9:2] !== 8'hC3) begin n_fail++; $display("FAIL rd_byte: got %h want c3", o_mbits[9:2]); end
    n_cmp++; if (o_mbits[1:0] !== x_mbits[1:0]) begin n_fail++; $display("FAIL rd_ninth: got %b want %b", o_mbits[1:0], x_mbits[1:0]); end
    model_frame(1'b1, 1'b1, 8'hFF, 10, 1'b0);
    run_frame(1'b1, 10'h2AA, 10, 1'b0, 8'hFF, 10, 1'b0);
    n_cmp++; if (o_mbits !== x_mbits) begin n_fail++; $display("FAIL rd_cleared: got %b want %b", o_mbits, x_mbits); end
  endtask

  task automatic test_abort();
    logic [9:0] w;
    w = {1'b0, 9'($urandom)};
    model_frame(1'b0, 1'b0, 8'h00, 10, 1'b0);
    run_frame(1'b0, w, 6, 1'b1, 8'h00, 10, 1'b0);
    n_cmp++; if (o_strobes !== x_strobes) begin n_fail++; $display("FAIL ab5_strobes: got %0d want %0d", o_strobes, x_strobes); end
    model_frame(1'b0, 1'b0, 8'h00, 10, 1'b0);
    run_frame(1'b0, w, 10, 1'b1, 8'h00, 10, 1'b0);
    n_cmp++; if (o_strobes !== x_strobes) begin n_fail++; $display("FAIL ab10_strobes: got %0d want %0d", o_strobes, x_strobes); end
    w = {1'b0, 9'($urandom)};
    model_frame(1'b0, 1'b1, 8'h00, 10, 1'b0);
    run_frame(1'b0, w, 10, 1'b0, 8'h00, 10, 1'b0);
    n_cmp++; if ((o_strobes !== 1) || (o_data !== w)) begin
      n_fail++; $display("FAIL ab_next: got %0d strobes data %h want 1 strobe data %h", o_strobes, o_data, w);
    end
  endtask

  task automatic test_abort_serial();
    logic [7:0] t;
    if (!m_rd_done) begin
      model_frame(1'b1, 1'b1, 8'h00, 10, 1'b0);
      run_frame(1'b1, 10'h211, 10, 1'b0, 8'h00, 10, 1'b0);
    end
    t = 8'($urandom);
    model_frame(1'b1, 1'b1, t, 3, 1'b0);
    run_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, t, 3, 1'b0);
    n_cmp++; if ((o_mbits !== x_mbits) || (o_stray !== 0)) begin
      n_fail++; $display("FAIL abs_bits: got %b stray %0d want %b stray 0", o_mbits, o_stray, x_mbits);
    end
    t = 8'($urandom);
    model_frame(1'b1, 1'b1, t, 10, 1'b0);
    run_frame(1'b1, {CMD_RD_DATA, 8'h5A}, 10, 1'b0, t, 10, 1'b0);
    n_cmp++; if (o_mbits !== x_mbits) begin n_fail++; $display("FAIL abs_still_read: got %b want %b", o_mbits, x_mbits); end
  endtask

  task automatic test_reset_mid_read();
    if (!m_rd_done) begin
      model_frame(1'b1, 1'b1, 8'h00, 10, 1'b0);
      run_frame(1'b1, 10'h233, 10, 1'b0, 8'h00, 10, 1'b0);
    end
    model_frame(1'b1, 1'b1, 8'h5A, 3, 1'b1);
    run_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 8'h5A, 3, 1'b1);
    n_cmp++; if (o_mbits !== x_mbits) begin n_fail++; $display("FAIL rst_bits: got %b want %b", o_mbits, x_mbits); end
    n_cmp++; if (o_rst_miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b want 0", o_rst_miso); end
    n_cmp++; if ((o_rst_valid !== 1'b0) || (o_rst_data !== 10'h000)) begin
      n_fail++; $display("FAIL rst_rx: got valid %b data %h want 0 000", o_rst_valid, o_rst_data);
    end
    model_frame(1'b1, 1'b1, 8'hA5, 10, 1'b0);
    run_frame(1'b1, 10'h2C1, 10, 1'b0, 8'hA5, 10, 1'b0);
    n_cmp++; if ((o_edge !== 12) || (o_mbits !== x_mbits)) begin
      n_fail++; $display("FAIL rst_after: got edge %0d bits %b want 12 %b", o_edge, o_mbits, x_mbits);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit         cmdb, abort;
      int         nb;
      logic [9:0] w;
      logic [7:0] t;
      cmdb = 1'($urandom);
      w    = 10'($urandom);
      t    = 8'($urandom);
      if (cmdb) w[9:8] = m_rd_done ? CMD_RD_DATA : CMD_RD_ADDR;
      else      w[9]   = 1'b0;
      abort = ($urandom_range(0, 3) == 0);
      nb    = abort ? int'($urandom_range(1, 10)) : 10;
      model_frame(cmdb, !abort, t, 10, 1'b0);
      run_frame(cmdb, w, nb, abort, t, 10, 1'b0);
      n_cmp++; if (o_strobes !== x_strobes) begin n_fail++; $display("FAIL rnd%0d_strobes: got %0d want %0d", n, o_strobes, x_strobes); end
      if (x_strobes == 1) begin
        n_cmp++; if ((o_edge !== 12) || (o_data !== w)) begin
          n_fail++; $display("FAIL rnd%0d_word: got edge %0d data %h want 12 %h", n, o_edge, o_data, w);
        end
      end
      n_cmp++; if ((o_mbits !== x_mbits) || (o_stray !== 0)) begin
        n_fail++; $display("FAIL rnd%0d_miso: got %b stray %0d want %b stray 0", n, o_mbits, o_stray, x_mbits);
      end
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_seq();
    test_abort();
    test_abort_serial();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
